// File: rtl/data_memory_arbiter_if.sv
// Two requester ports plus the Data_memory command/return signals of data_memory_arbiter.
// slave = arbiter side, master = requesters and memory side.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif
interface data_memory_arbiter_if #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = `INTERNAL_BITS
);
  logic                 req0_valid, req0_write, req0_ready;
  logic [ADDR_BITS-1:0] req0_addr;
  logic [DATA_BITS-1:0] req0_wdata;
  logic                 rsp0_valid;
  logic [DATA_BITS-1:0] rsp0_rdata;

  logic                 req1_valid, req1_write, req1_ready;
  logic [ADDR_BITS-1:0] req1_addr;
  logic [DATA_BITS-1:0] req1_wdata;
  logic                 rsp1_valid;
  logic [DATA_BITS-1:0] rsp1_rdata;

  logic                 mem_read_enable, mem_write_enable;
  logic [ADDR_BITS-1:0] mem_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic [DATA_BITS-1:0] mem_data_out;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_read_enable, mem_write_enable, mem_address, mem_write_data,
    input  mem_data_out
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_read_enable, mem_write_enable, mem_address, mem_write_data,
    output mem_data_out
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin, burst-limited sharing of one Data_memory port by two requesters; optional DMEM_ARB_STATS_EN counters.
// Latency: command registered on the accept edge; rspN valid MEM_LAT+1 edges after that edge.
// Backpressure: reqN_ready withheld from the non-granted port; responses cannot be stalled.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif
module data_memory_arbiter #(
  parameter int ADDR_BITS = 13,
  parameter int DATA_BITS = `INTERNAL_BITS,
  parameter int MEM_LAT   = 1,
  parameter int BURST     = 4
) (
  input  logic CLK,
  input  logic RST,
  data_memory_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_gnt0,
  output logic [15:0] stat_gnt1,
  output logic [15:0] stat_conflict
`endif
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [3:0] BURST_C = 4'(BURST);

  state_t               state;
  logic [3:0]           cnt;
  logic                 rr;
  logic                 gnt_vld, gnt_port;
  logic                 sel_write;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;
  logic [MEM_LAT:0]     tag_vld, tag_port;

  // Grant is held off during reset so every output reads 0 while RST is high.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (bus.req0_valid || bus.req1_valid) begin
            gnt_vld  = 1'b1;
            gnt_port = (bus.req0_valid && bus.req1_valid) ? rr : bus.req1_valid;
          end
        end
        OWN0: begin
          if (bus.req0_valid && (!bus.req1_valid || cnt < BURST_C)) begin
            gnt_vld = 1'b1;
          end else if (bus.req1_valid) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b1;
          end
        end
        OWN1: begin
          if (bus.req1_valid && (!bus.req0_valid || cnt < BURST_C)) begin
            gnt_vld  = 1'b1;
            gnt_port = 1'b1;
          end else if (bus.req0_valid) begin
            gnt_vld = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = gnt_vld & ~gnt_port;
  assign bus.req1_ready = gnt_vld & gnt_port;
  assign sel_write      = gnt_port ? bus.req1_write : bus.req0_write;
  assign sel_addr       = gnt_port ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata      = gnt_port ? bus.req1_wdata : bus.req0_wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state                <= IDLE;
      cnt                  <= '0;
      rr                   <= 1'b0;
      bus.mem_read_enable  <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_write_data   <= '0;
    end else begin
      bus.mem_read_enable  <= gnt_vld & ~sel_write;
      bus.mem_write_enable <= gnt_vld & sel_write;
      if (gnt_vld) begin
        bus.mem_address    <= sel_addr;
        bus.mem_write_data <= sel_wdata;
        rr                 <= ~gnt_port;
        if (state == (gnt_port ? OWN1 : OWN0)) begin
          if (cnt != BURST_C) cnt <= cnt + 4'd1;
        end else begin
          state <= gnt_port ? OWN1 : OWN0;
          cnt   <= 4'd1;
        end
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end
  end

  // Read tags ride alongside the memory pipeline; the last stage steers Data_out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_vld        <= '0;
      tag_port       <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_rdata <= '0;
      bus.rsp1_rdata <= '0;
    end else begin
      tag_vld        <= {tag_vld[MEM_LAT-1:0], gnt_vld & ~sel_write};
      tag_port       <= {tag_port[MEM_LAT-1:0], gnt_port};
      bus.rsp0_valid <= tag_vld[MEM_LAT] & ~tag_port[MEM_LAT];
      bus.rsp1_valid <= tag_vld[MEM_LAT] & tag_port[MEM_LAT];
      if (tag_vld[MEM_LAT] && !tag_port[MEM_LAT]) bus.rsp0_rdata <= bus.mem_data_out;
      if (tag_vld[MEM_LAT] && tag_port[MEM_LAT])  bus.rsp1_rdata <= bus.mem_data_out;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt_vld && !gnt_port && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt_vld && gnt_port && stat_gnt1 != 16'hFFFF)  stat_gnt1 <= stat_gnt1 + 16'd1;
      if (gnt_vld && bus.req0_valid && bus.req1_valid && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port Data_memory (Read_enable/Write_enable/Address/Write_data/Data_out) between two requesters, e.g. the core load/store path (port 0) and a loader/DMA path (port 1).
- Arbitration is round-robin with a bounded burst hold.
- Memory commands are issued from registers, and read data returns to the issuing requester with a fixed latency.

Parameters:
- ADDR_BITS, 13, memory word address width.
- DATA_BITS, `INTERNAL_BITS, data width.
- MEM_LAT, 1, cycles from the edge that samples Read_enable until Data_out is valid (1 or 2 supported).
- BURST, 4, maximum consecutive accepts by one owner while the other requester waits (1..15).

Ports:
- CLK  in  1  clock; drives arbiter and memory
- RST  in  1  asynchronous active-high reset
- req0_valid  in  1  port 0 request
- req0_write  in  1  1=write, 0=read
- req0_addr  in  ADDR_BITS  word address
- req0_wdata  in  DATA_BITS  write data
- req0_ready  out  1  request accepted this cycle
- rsp0_valid  out  1  read data valid
- rsp0_rdata  out  DATA_BITS  read data
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0
- mem_read_enable  out  1  to Data_memory Read_enable
- mem_write_enable  out  1  to Write_enable
- mem_address  out  ADDR_BITS  to Address
- mem_write_data  out  DATA_BITS  to Write_data
- mem_data_out  in  DATA_BITS  from Data_out

Behaviour:
- Reset (async, RST=1):
  - all outputs 0; FSM=IDLE; rr pointer=0 (port 0 preferred); burst counter=0.
  - response pipeline valid bits cleared; in-flight reads are discarded and produce no rsp.
- Accept rules:
  - reqN_ready is combinational from FSM state and the valid inputs. At most one ready per cycle.
  - Accept = reqN_valid & reqN_ready at a rising edge. Requesters hold all req fields stable until accepted.
- FSM states IDLE, OWN0, OWN1:
  - IDLE: no valids → stay. One valid → grant it. Both valid → grant rr pointer's port. The granted port goes to OWNn, cnt=1.
  - OWNn with reqN_valid and (other idle or cnt<BURST): grant N, cnt=cnt+1 (saturates at BURST).
  - OWNn with reqN_valid, cnt==BURST and other valid: grant other, go to OWNother, cnt=1.
  - OWNn with !reqN_valid: other valid → grant other, OWNother, cnt=1; else → IDLE, cnt=0.
  - rr pointer = port not most recently granted, updated on every accept.
- Issue:
  - on accept edge, mem_* registers load: read_enable=!write, write_enable=write, address, write_data.
  - Next cycle without accept: both enables 0; address/write_data hold.
  - Throughput: 1 access/cycle; back-to-back accepts from either port allowed.
- Read return:
  - tag pipeline {valid, port} of depth MEM_LAT+1 tracks each read.
  - On the edge where the tag exits, rspN_rdata <= mem_data_out and rspN_valid=1 for one cycle.
  - With MEM_LAT=1: accept at edge E0 → rsp valid in the cycle after E2.
  - rdata holds its last value when valid=0.
- Writes: no response. A read accepted after a write to the same address returns the new data (in-order memory).
- Ordering: responses per port in accept order; no response backpressure.

Optional Feature:
- DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_gnt0, stat_gnt1, stat_conflict (16 bits each, reset 0, saturate at 16'hFFFF).
  - stat_gntN counts accepts on port N.
  - stat_conflict counts cycles where both valid and only one is accepted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Preload Memory[i]=i for i=0..99; port 0 reads addr 0..99 back-to-back, port 1 idle → 100 accepts in 100 cycles; rsp0_rdata=i, each 2 cycles after the accept cycle (MEM_LAT=1).
- Port 1 writes Memory[i]=100-i for i=0..99, then port 0 reads addr 0..99 → rsp0_rdata=100-i; rsp1_valid never asserted.
- Both ports continuously valid from IDLE, BURST=4 → grant pattern 0,0,0,0,1,1,1,1,0,...; with stats enabled, stat_conflict = number of both-valid cycles and stat_gnt0=stat_gnt1 after 64 accepts.
- Port 0 drops valid after 2 accepts while port 1 waits → port 1 granted the next cycle (no idle cycle); reads return to the correct rsp port.
- Same cycle: port 0 write addr 5=77, port 1 read addr 5 → port 0 wins (rr=0) and the read follows; rsp1_rdata=77.
- Assert RST while 2 reads are in flight → all outputs 0 immediately; no rsp after release; the first request after release is accepted in the first cycle.
